pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning PC loaded on reset.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, meaning max FETCH cycles without ack before fault.
REQ-003 SHALL have port i_PcSequencer_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_PcSequencer_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_PcSequencer_pause  input  1  global stall; freezes sequencer.
REQ-006 SHALL have port o_PcSequencer_imemReq  output  1  instruction fetch request.
REQ-007 SHALL have port o_PcSequencer_imemAddr  output  32  fetch address, always equal to o_PcSequencer_pc.
REQ-008 SHALL have port i_PcSequencer_imemAck  input  1  fetch data valid on i_PcSequencer_instr this cycle.
REQ-009 SHALL have port i_PcSequencer_instr  input  32  fetched instruction word.
REQ-010 SHALL have port o_PcSequencer_ir  output  32  latched instruction register.
REQ-011 SHALL have port o_PcSequencer_pc  output  32  current PC, fed to branch unit.
REQ-012 SHALL have port o_PcSequencer_BRop  output  3  branch op to branch unit: 010 jump, 100 beq, 001 bne, 000 sequential.
REQ-013 SHALL have port i_PcSequencer_nextPc  input  32  next PC computed by branch unit.
REQ-014 SHALL have port o_PcSequencer_execStart  output  1  one-cycle pulse starting datapath execution.
REQ-015 SHALL have port i_PcSequencer_execDone  input  1  datapath finished current instruction.
REQ-016 SHALL have port o_PcSequencer_retire  output  1  one-cycle pulse when PC advances.
REQ-017 SHALL have port o_PcSequencer_instret  output  32  retired-instruction count.
REQ-018 SHALL have port o_PcSequencer_state  output  3  FSM state encoding.
REQ-019 SHALL have port o_PcSequencer_fault  output  1  sticky fault flag.

Function
REQ-020 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, UPDATE=4, FAULT=7; other codes SHALL go to FAULT.
REQ-021 IDLE SHALL last one cycle then go to FETCH.
REQ-022 FETCH: imemReq=1; on imemAck, ir<=instr and go to DECODE; wait counter cleared on FETCH entry.
REQ-023 FETCH SHALL go to FAULT when ACK_TIMEOUT consecutive non-paused cycles elapse without ack.
REQ-024 DECODE SHALL last one cycle; BRop decoded from ir[31:26]: 000010->010, 000100->100, 000101->001, else 000; BRop SHALL be 000 in all other states except EXEC and UPDATE, where it holds the decoded value.
REQ-025 EXEC entry SHALL pulse execStart for exactly one cycle; BRop!=000 SHALL go to UPDATE next cycle without waiting; otherwise wait for execDone then UPDATE.
REQ-026 UPDATE SHALL load pc<=nextPc, pulse retire, increment instret, go to FETCH; fetch latency from UPDATE to first imemReq is one cycle.
REQ-027 UPDATE with nextPc[1:0]!=00 SHALL go to FAULT with pc unchanged, no retire, no instret increment.
REQ-028 FAULT SHALL be terminal until reset; fault=1, imemReq=0, no pulses.
REQ-029 pause=1 SHALL hold state, pc, ir, instret, wait counter; force imemReq=0, execStart=0, retire=0.
REQ-030 pause with imemAck or execDone in same cycle: pause wins, ack/done ignored (requester must re-present).
REQ-031 execDone outside EXEC and imemAck outside FETCH SHALL be ignored.
REQ-032 instret SHALL wrap 32'hFFFF_FFFF -> 0 without fault.

Reset
REQ-033 rst=1 SHALL immediately set state=IDLE, pc=RESET_PC, ir=0, instret=0, fault=0, BRop=000, imemReq=0, execStart=0, retire=0, wait counter=0.
REQ-034 rst asserted mid-FETCH/EXEC SHALL abort the instruction with no retire; sequencing restarts from IDLE after release.

Verification
REQ-035 Reset release, instr=32'h0000_0000 ack at once, execDone 2 cycles after execStart, nextPc=pc+4 -> imemAddr 3000,3004,3008; retire every 6 cycles; instret=3 after 3.
REQ-036 instr=32'h1000_0003 (beq) -> BRop=100 in EXEC; UPDATE with no execDone wait; pc<=nextPc=32'h0000_3010.
REQ-037 No ack for 16 FETCH cycles -> state=7, fault=1, imemReq=0 until rst.
REQ-038 pause=1 for 5 cycles during EXEC with execDone pulsing -> no transition, no retire; after release, new execDone completes instruction.
REQ-039 nextPc=32'h0000_3006 in UPDATE -> FAULT, pc stays 32'h0000_3000, instret unchanged.
REQ-040 instret preloaded to 32'hFFFF_FFFF via long run/force, one retire -> instret=0, fault=0.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch/decode/execute/update sequencer that owns the PC, the
//            instruction register and the retired-instruction counter.
// Revision : 1.0 - initial release
//==============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        i_PcSequencer_clk,
    input  logic        i_PcSequencer_rst,
    input  logic        i_PcSequencer_pause,
    output logic        o_PcSequencer_imemReq,
    output logic [31:0] o_PcSequencer_imemAddr,
    input  logic        i_PcSequencer_imemAck,
    input  logic [31:0] i_PcSequencer_instr,
    output logic [31:0] o_PcSequencer_ir,
    output logic [31:0] o_PcSequencer_pc,
    output logic [2:0]  o_PcSequencer_BRop,
    input  logic [31:0] i_PcSequencer_nextPc,
    output logic        o_PcSequencer_execStart,
    input  logic        i_PcSequencer_execDone,
    output logic        o_PcSequencer_retire,
    output logic [31:0] o_PcSequencer_instret,
    output logic [2:0]  o_PcSequencer_state,
    output logic        o_PcSequencer_fault
);

    localparam int                WAIT_W      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(ACK_TIMEOUT - 1);

    localparam logic [2:0] c_brop_seq  = 3'b000;
    localparam logic [2:0] c_brop_jump = 3'b010;
    localparam logic [2:0] c_brop_beq  = 3'b100;
    localparam logic [2:0] c_brop_bne  = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_FAULT  = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_pc;
    logic [31:0]       r_ir;
    logic [31:0]       r_instret;
    logic [WAIT_W-1:0] r_wait;
    logic              r_started;

    logic              w_imem_req;
    logic              w_exec_start;
    logic              w_retire;
    logic [2:0]        w_brop_dec;

    always_comb begin
        w_brop_dec = c_brop_seq;
        case (r_ir[31:26])
            6'b000010: w_brop_dec = c_brop_jump;
            6'b000100: w_brop_dec = c_brop_beq;
            6'b000101: w_brop_dec = c_brop_bne;
            default:   w_brop_dec = c_brop_seq;
        endcase
    end

    // Every legal state is frozen by pause; unknown encodings fall into FAULT regardless.
    always_comb begin
        w_state_next = r_state;
        w_imem_req   = 1'b0;
        w_exec_start = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!i_PcSequencer_pause) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (!i_PcSequencer_pause) begin
                    w_imem_req = 1'b1;
                    if (i_PcSequencer_imemAck)     w_state_next = ST_DECODE;
                    else if (r_wait == c_wait_last) w_state_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                if (!i_PcSequencer_pause) w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (!i_PcSequencer_pause) begin
                    w_exec_start = !r_started;
                    if ((w_brop_dec != c_brop_seq) || i_PcSequencer_execDone)
                        w_state_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (!i_PcSequencer_pause) begin
                    if (i_PcSequencer_nextPc[1:0] != 2'b00) begin
                        w_state_next = ST_FAULT;
                    end else begin
                        w_retire     = 1'b1;
                        w_state_next = ST_FETCH;
                    end
                end
            end
            ST_FAULT: w_state_next = ST_FAULT;
            default:  w_state_next = ST_FAULT;
        endcase
    end

    always_ff @(posedge i_PcSequencer_clk or posedge i_PcSequencer_rst) begin
        if (i_PcSequencer_rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC;
            r_ir      <= 32'd0;
            r_instret <= 32'd0;
            r_wait    <= '0;
            r_started <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (!i_PcSequencer_pause) begin
                // The ack wait counter only runs inside FETCH, so it is zero on every entry.
                if (r_state != ST_FETCH) r_wait <= '0;
                case (r_state)
                    ST_FETCH: begin
                        if (i_PcSequencer_imemAck) r_ir   <= i_PcSequencer_instr;
                        else                       r_wait <= r_wait + 1'b1;
                    end
                    ST_DECODE: r_started <= 1'b0;
                    ST_EXEC:   r_started <= 1'b1;
                    ST_UPDATE: begin
                        if (w_retire) begin
                            r_pc      <= i_PcSequencer_nextPc;
                            r_instret <= r_instret + 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_PcSequencer_imemReq   = w_imem_req;
    assign o_PcSequencer_imemAddr  = r_pc;
    assign o_PcSequencer_pc        = r_pc;
    assign o_PcSequencer_ir        = r_ir;
    assign o_PcSequencer_BRop      = ((r_state == ST_EXEC) || (r_state == ST_UPDATE)) ? w_brop_dec : c_brop_seq;
    assign o_PcSequencer_execStart = w_exec_start;
    assign o_PcSequencer_retire    = w_retire;
    assign o_PcSequencer_instret   = r_instret;
    assign o_PcSequencer_state     = r_state;
    assign o_PcSequencer_fault     = (r_state == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer with a cycle model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int          TMO    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pause = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [31:0] next_pc = 32'd0;
    logic        auto_done = 1'b0;
    logic        man_done = 1'b0;
    logic        exec_done;
    assign exec_done = auto_done | man_done;

    logic        req, start, retire, fault;
    logic [31:0] addr, ir, pc, instret;
    logic [2:0]  brop, state;

    // Stimulus configuration (written by the main process only)
    logic        cfg_ack = 1'b0, cfg_ack_always = 1'b0, cfg_npc_fixed = 1'b0, preload = 1'b0;
    logic [31:0] cfg_instr = 32'd0, cfg_npc = 32'd0;
    int          cfg_done_delay = 99;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    pc_sequencer #(.RESET_PC(RST_PC), .ACK_TIMEOUT(TMO)) dut (
        .i_PcSequencer_clk       (clk),
        .i_PcSequencer_rst       (rst),
        .i_PcSequencer_pause     (pause),
        .o_PcSequencer_imemReq   (req),
        .o_PcSequencer_imemAddr  (addr),
        .i_PcSequencer_imemAck   (imem_ack),
        .i_PcSequencer_instr     (instr),
        .o_PcSequencer_ir        (ir),
        .o_PcSequencer_pc        (pc),
        .o_PcSequencer_BRop      (brop),
        .i_PcSequencer_nextPc    (next_pc),
        .o_PcSequencer_execStart (start),
        .i_PcSequencer_execDone  (exec_done),
        .o_PcSequencer_retire    (retire),
        .o_PcSequencer_instret   (instret),
        .o_PcSequencer_state     (state),
        .o_PcSequencer_fault     (fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] dec_brop(input logic [31:0] w);
        case (w[31:26])
            6'b000010: return 3'b010;
            6'b000100: return 3'b100;
            6'b000101: return 3'b001;
            default:   return 3'b000;
        endcase
    endfunction

    // Behavioural model: phase number, PC, IR, retire count and progress counters
    int          m_st = 0, m_wait = 0, m_exec_cnt = 0;
    logic [31:0] m_pc = RST_PC, m_ir = 32'd0, m_instret = 32'd0;
    bit          m_started = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_pc = RST_PC; m_ir = 0; m_instret = 0;
            m_started = 0; m_wait = 0; m_exec_cnt = 0;
        end else begin
            if (preload) m_instret = 32'hFFFF_FFFF;
            if (!pause) begin
                case (m_st)
                    0: begin m_st = 1; m_wait = 0; end
                    1: begin
                        if (imem_ack) begin m_ir = instr; m_st = 2; end
                        else begin
                            m_wait++;
                            if (m_wait >= TMO) m_st = 7;
                        end
                    end
                    2: begin m_st = 3; m_started = 0; m_exec_cnt = 0; end
                    3: begin
                        m_started = 1;
                        m_exec_cnt++;
                        if (dec_brop(m_ir) != 3'b000 || exec_done) m_st = 4;
                    end
                    4: begin
                        if (next_pc[1:0] != 2'b00) m_st = 7;
                        else begin m_pc = next_pc; m_instret++; m_st = 1; m_wait = 0; end
                    end
                    default: m_st = 7;
                endcase
            end
        end
    end

    // Environment: memory and datapath responders driven from the model's view
    always @(posedge clk) begin
        #1;
        imem_ack  = cfg_ack_always || (cfg_ack && m_st == 1);
        instr     = cfg_instr;
        auto_done = (m_st == 3) && (m_exec_cnt == cfg_done_delay);
        next_pc   = cfg_npc_fixed ? cfg_npc : m_pc + 32'd4;
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("state",     {29'd0, state},  m_st);
            check("pc",        pc,              m_pc);
            check("imemAddr",  addr,            m_pc);
            check("ir",        ir,              m_ir);
            check("instret",   instret,         m_instret);
            check("fault",     {31'd0, fault},  {31'd0, m_st == 7});
            check("imemReq",   {31'd0, req},    {31'd0, m_st == 1 && !pause});
            check("execStart", {31'd0, start},  {31'd0, m_st == 3 && !m_started && !pause});
            check("retire",    {31'd0, retire}, {31'd0, m_st == 4 && !pause && next_pc[1:0] == 2'b00});
            check("BRop",      {29'd0, brop},   (m_st == 3 || m_st == 4) ? {29'd0, dec_brop(m_ir)} : 32'd0);
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_state",   {29'd0, state}, 32'd0);
        check("rst_pc",      pc, 32'h0000_3000);
        check("rst_ir",      ir, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_flags",   {27'd0, fault, req, start, retire, 1'b0}, 32'd0);
        check("rst_brop",    {29'd0, brop}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state == s) return;
        end
        n_checks++; n_fail++;
        $display("FAIL %s timeout waiting for state actual=%0d required=%0d", name, state, s);
    endtask

    task automatic wait_retire(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (retire) return;
        end
        n_checks++; n_fail++;
        $display("FAIL %s timeout waiting for retire actual=0 required=1", name);
    endtask

    initial begin : watchdog
        #100000;
        n_fail++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : main
        logic [31:0] ops [3];
        logic [2:0]  ops_br [3];
        int          last, n_req;

        // Straight-line code with pc+4, execDone two cycles after execStart
        cfg_ack_always = 1; cfg_instr = 32'h0000_0000; cfg_done_delay = 2; cfg_npc_fixed = 0;
        do_reset();
        last = 0;
        for (int k = 0; k < 3; k++) begin
            wait_retire(20, "seq_retire");
            check("seq_addr", addr, 32'h0000_3000 + 32'(4 * k));
            if (k > 0) check("seq_interval", cyc - last, 6);
            last = cyc;
        end
        @(negedge clk);
        check("seq_instret", instret, 32'd3);

        // beq: no execDone wait, PC taken from branch unit
        cfg_ack_always = 0; cfg_ack = 1; cfg_instr = 32'h1000_0003; cfg_done_delay = 99;
        cfg_npc_fixed = 1; cfg_npc = 32'h0000_3010;
        do_reset();
        wait_state(3'd3, 10, "beq_exec");
        check("beq_brop_exec", {29'd0, brop}, 32'h4);
        check("beq_start", {31'd0, start}, 32'd1);
        @(negedge clk);
        check("beq_update", {29'd0, state}, 32'd4);
        check("beq_retire", {31'd0, retire}, 32'd1);
        @(negedge clk);
        check("beq_pc", pc, 32'h0000_3010);
        check("beq_brop_fetch", {29'd0, brop}, 32'd0);

        // Remaining opcode classes
        ops[0] = 32'h0800_0000; ops_br[0] = 3'b010;
        ops[1] = 32'h1400_0000; ops_br[1] = 3'b001;
        ops[2] = 32'hFC00_0000; ops_br[2] = 3'b000;
        for (int k = 0; k < 3; k++) begin
            cfg_instr = ops[k]; cfg_npc_fixed = 0; cfg_done_delay = 1;
            do_reset();
            wait_state(3'd3, 10, "op_exec");
            check("op_brop", {29'd0, brop}, {29'd0, ops_br[k]});
            wait_retire(10, "op_retire");
        end

        // Fetch timeout with a 3-cycle pause that must not count
        cfg_ack = 0; cfg_ack_always = 0;
        do_reset();
        n_req = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            pause = (i >= 4 && i < 7);
            @(negedge clk);
            if (req) n_req++;
            if (state == 3'd7) break;
        end
        pause = 0;
        check("tmo_req_cycles", n_req, 16);
        check("tmo_state", {29'd0, state}, 32'd7);
        check("tmo_fault", {31'd0, fault}, 32'd1);
        check("tmo_req", {31'd0, req}, 32'd0);
        cfg_ack_always = 1;
        repeat (5) @(negedge clk);
        check("tmo_sticky", {29'd0, state}, 32'd7);
        cfg_ack_always = 0;

        // Pause in EXEC with execDone pulsing, then a real execDone
        cfg_ack = 1; cfg_instr = 32'd0; cfg_done_delay = 99; cfg_npc_fixed = 0;
        do_reset();
        wait_state(3'd3, 10, "pz_exec");
        check("pz_start", {31'd0, start}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            pause = 1; man_done = (i % 2 == 0);
            @(negedge clk);
            check("pz_hold", {29'd0, state}, 32'd3);
            check("pz_no_retire", {31'd0, retire}, 32'd0);
        end
        @(posedge clk); #1; pause = 0; man_done = 0;
        @(negedge clk);
        check("pz_after", {29'd0, state}, 32'd3);
        @(posedge clk); #1; man_done = 1;
        @(negedge clk);
        @(posedge clk); #1; man_done = 0;
        @(negedge clk);
        check("pz_update", {29'd0, state}, 32'd4);
        check("pz_retire", {31'd0, retire}, 32'd1);

        // Reset during EXEC of the next instruction aborts it
        wait_state(3'd3, 10, "abort_exec");
        do_reset();
        wait_state(3'd1, 3, "abort_refetch");

        // Misaligned next PC
        cfg_done_delay = 2; cfg_npc_fixed = 1; cfg_npc = 32'h0000_3006;
        do_reset();
        wait_state(3'd4, 12, "mis_update");
        check("mis_retire", {31'd0, retire}, 32'd0);
        @(negedge clk);
        check("mis_state", {29'd0, state}, 32'd7);
        check("mis_pc", pc, 32'h0000_3000);
        check("mis_instret", instret, 32'd0);

        // instret wrap
        cfg_npc_fixed = 0;
        do_reset();
        wait_state(3'd4, 12, "wrap_update");
        #2;
        force dut.r_instret = 32'hFFFF_FFFF;
        preload = 1;
        #1;
        release dut.r_instret;
        @(posedge clk); #1; preload = 0;
        @(negedge clk);
        check("wrap_instret", instret, 32'd0);
        check("wrap_fault", {31'd0, fault}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
